// File: rtl/mem_write_pkg.sv
// Shared definitions for the SPI RAM write path: SPI opcodes, write_size
// encodings, FSM state type and frame-building helpers.
// Optional feature macro: MEM_WRITE_WREN_EN (adds WREN / WREN_GAP states).
package mem_write_pkg;

    localparam logic [7:0] SPI_CMD_WRITE = 8'h02;
    localparam logic [7:0] SPI_CMD_READ  = 8'h03;
    localparam logic [7:0] SPI_CMD_WREN  = 8'h06;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
`ifdef MEM_WRITE_WREN_EN
        , ST_WREN
        , ST_WREN_GAP
`endif
    } state_t;

    // Frame length in bits: opcode + 24-bit address + N data bytes.
    // The reserved size code is sent as a full word.
    function automatic logic [6:0] frameBits(input logic [1:0] size);
        logic [6:0] bits;
        case (size)
            SIZE_BYTE: bits = 7'd40;
            SIZE_HALF: bits = 7'd48;
            default:   bits = 7'd64;
        endcase
        return bits;
    endfunction

    // MSB-aligned frame; data bytes are little-endian so byte 0 leads.
    // Shorter frames simply stop before the unused trailing bytes.
    function automatic logic [63:0] buildFrame(input logic [23:0] addr,
                                               input logic [31:0] data);
        return {SPI_CMD_WRITE, addr, data[7:0], data[15:8], data[23:16], data[31:24]};
    endfunction

endpackage

// File: rtl/mem_write_spi_tx_shifter.sv
// SPI mode-0 transmit shifter: takes an MSB-aligned parallel word and a bit
// count, then generates sclk (clk/2) and mosi, flagging the last high phase.
module spi_tx_shifter (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [63:0] i_data,
    input  logic [6:0]  i_bitCount,
    output logic        o_sclk,
    output logic        o_mosi,
    output logic        o_lastBit
);

    logic [63:0] r_shift;
    logic [5:0]  r_bitCnt;
    logic        r_sclk;
    logic        r_mosi;
    logic        r_active;

    // Present the first bit on load, then alternate low/high phases,
    // advancing mosi only as sclk falls so data is stable on the rising edge.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_shift  <= '0;
            r_bitCnt <= '0;
            r_sclk   <= 1'b0;
            r_mosi   <= 1'b0;
            r_active <= 1'b0;
        end else if (i_load) begin
            r_shift  <= {i_data[62:0], 1'b0};
            r_bitCnt <= 6'(i_bitCount - 7'd1);
            r_sclk   <= 1'b0;
            r_mosi   <= i_data[63];
            r_active <= 1'b1;
        end else if (r_active) begin
            if (!r_sclk) begin
                r_sclk <= 1'b1;
            end else begin
                r_sclk <= 1'b0;
                if (r_bitCnt == 6'd0) begin
                    r_active <= 1'b0;
                    r_mosi   <= 1'b0;
                end else begin
                    r_mosi   <= r_shift[63];
                    r_shift  <= {r_shift[62:0], 1'b0};
                    r_bitCnt <= r_bitCnt - 6'd1;
                end
            end
        end
    end

    assign o_sclk    = r_sclk;
    assign o_mosi    = r_mosi;
    assign o_lastBit = r_active & r_sclk & (r_bitCnt == 6'd0);

endmodule

// File: rtl/mem_write.sv
// SPI RAM write master: sends opcode 0x02, a 24-bit address and 1/2/4 data
// bytes for each core store. Defining MEM_WRITE_WREN_EN prefixes every write
// with a separate WREN (0x06) frame followed by a two-cycle cs-high gap.
module mem_write
    import mem_write_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [23:0] target_address,
    input  logic [31:0] write_data,
    input  logic [1:0]  write_size,
    input  logic        start_write,
    output logic        write_done,
    output logic        busy,
    output logic        sclk,
    output logic        mosi,
    output logic        cs
);

    state_t      r_state;
    logic        r_cs;
    logic        r_busy;
    logic        r_done;

    state_t      w_nextState;
    logic        w_nextCs;
    logic        w_nextBusy;
    logic        w_nextDone;
    logic        w_load;
    logic [63:0] w_loadData;
    logic [6:0]  w_loadBits;
    logic        w_lastBit;

`ifdef MEM_WRITE_WREN_EN
    logic [63:0] r_frame;
    logic [6:0]  r_bits;
    logic        r_gapCnt;
    logic        w_nextGap;
    logic        w_capture;
`endif

    spi_tx_shifter u_shifter (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_load     (w_load),
        .i_data     (w_loadData),
        .i_bitCount (w_loadBits),
        .o_sclk     (sclk),
        .o_mosi     (mosi),
        .o_lastBit  (w_lastBit)
    );

    // Next-state and next-output decode; every output is registered below.
    always_comb begin
        w_nextState = r_state;
        w_nextCs    = r_cs;
        w_nextBusy  = r_busy;
        w_nextDone  = r_done;
        w_load      = 1'b0;
        w_loadData  = buildFrame(target_address, write_data);
        w_loadBits  = frameBits(write_size);
`ifdef MEM_WRITE_WREN_EN
        w_nextGap   = r_gapCnt;
        w_capture   = 1'b0;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start_write && !r_done) begin
                    w_nextCs   = 1'b0;
                    w_nextBusy = 1'b1;
                    w_load     = 1'b1;
`ifdef MEM_WRITE_WREN_EN
                    w_capture   = 1'b1;
                    w_loadData  = {SPI_CMD_WREN, 56'd0};
                    w_loadBits  = 7'd8;
                    w_nextState = ST_WREN;
`else
                    w_nextState = ST_SHIFT;
`endif
                end
            end
`ifdef MEM_WRITE_WREN_EN
            ST_WREN: begin
                if (w_lastBit) begin
                    w_nextCs    = 1'b1;
                    w_nextGap   = 1'b0;
                    w_nextState = ST_WREN_GAP;
                end
            end
            ST_WREN_GAP: begin
                if (r_gapCnt) begin
                    w_nextCs    = 1'b0;
                    w_load      = 1'b1;
                    w_loadData  = r_frame;
                    w_loadBits  = r_bits;
                    w_nextState = ST_SHIFT;
                end else begin
                    w_nextGap = 1'b1;
                end
            end
`endif
            ST_SHIFT: begin
                if (w_lastBit) begin
                    w_nextCs    = 1'b1;
                    w_nextBusy  = 1'b0;
                    w_nextDone  = 1'b1;
                    w_nextState = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!start_write) begin
                    w_nextDone  = 1'b0;
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cs     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
`ifdef MEM_WRITE_WREN_EN
            r_frame  <= '0;
            r_bits   <= '0;
            r_gapCnt <= 1'b0;
`endif
        end else begin
            r_state  <= w_nextState;
            r_cs     <= w_nextCs;
            r_busy   <= w_nextBusy;
            r_done   <= w_nextDone;
`ifdef MEM_WRITE_WREN_EN
            r_gapCnt <= w_nextGap;
            if (w_capture) begin
                r_frame <= buildFrame(target_address, write_data);
                r_bits  <= frameBits(write_size);
            end
`endif
        end
    end

    assign cs         = r_cs;
    assign busy       = r_busy;
    assign write_done = r_done;

endmodule

// File: tb/tb_mem_write.sv
// Scoreboard bench for mem_write: stimulus pushes the expected SPI frame,
// an SPI slave monitor decodes every cs-low frame and checks it.
module tb_mem_write;

   typedef struct {
      logic [63:0] frame;
      int          nbits;
      int          csLow;
      logic        done;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [23:0] target_address;
   logic [31:0] write_data;
   logic [1:0]  write_size;
   logic        start_write;
   logic        write_done;
   logic        busy;
   logic        sclk;
   logic        mosi;
   logic        cs;

   exp_t expQ[$];
   int   nChecks = 0;
   int   nFails  = 0;

   mem_write dut (
      .clk            (clk),
      .rst            (rst),
      .target_address (target_address),
      .write_data     (write_data),
      .write_size     (write_size),
      .start_write    (start_write),
      .write_done     (write_done),
      .busy           (busy),
      .sclk           (sclk),
      .mosi           (mosi),
      .cs             (cs)
   );

   // 10-unit system clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never returns
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nFails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // SPI slave model: samples away from the active edge, shifts in mosi on
   // each sclk rise, measures cs-low length and cs-high gap between frames.
   logic [63:0] monBits;
   int          monNb;
   int          monCsLow;
   int          monCsHigh;
   bit          monInFrame = 1'b0;
   bit          monSeen    = 1'b0;
   logic        monPrevSclk = 1'b0;
   logic        monPrevRst  = 1'b0;

   always @(negedge clk) begin
      if (cs === 1'b0) begin
         if (!monInFrame) begin
            monInFrame = 1'b1;
            monBits    = '0;
            monNb      = 0;
            monCsLow   = 0;
            if (monSeen) checkOutput("csGapAtLeast2", 64'(monCsHigh >= 2), 64'd1);
         end
         monCsLow++;
         if (sclk === 1'b1 && monPrevSclk === 1'b0) begin
            monBits = {monBits[62:0], mosi};
            monNb++;
         end
      end else begin
         if (monInFrame) begin
            monInFrame = 1'b0;
            monSeen    = 1'b1;
            monCsHigh  = 0;
            if (!monPrevRst) begin
               if (expQ.size() == 0) begin
                  nChecks++;
                  nFails++;
                  $display("[TB] FAIL unexpectedFrame: got 0x%0h (%0d bits), expected no frame", monBits, monNb);
               end else begin
                  exp_t e;
                  e = expQ.pop_front();
                  checkOutput("frameBitCount", 64'(monNb), 64'(e.nbits));
                  checkOutput("frameContent", monBits, e.frame);
                  checkOutput("csLowCycles", 64'(monCsLow), 64'(e.csLow));
                  checkOutput("doneWithCsRise", 64'(write_done), 64'(e.done));
               end
            end
         end
         monCsHigh++;
      end
      monPrevSclk = sclk;
      monPrevRst  = rst;
   end

   // Issue one store, push its expected frame(s), and check handshake timing
   task automatic applyStimulus(input logic [23:0] addr, input logic [31:0] data, input logic [1:0] size,
                                input logic [63:0] expFrame, input int expBits, input int expCsLow,
                                input bit dropEarly);
      int n;
      int bad;
      int expLat;
      expLat = 1 + expCsLow;
`ifdef MEM_WRITE_WREN_EN
      expQ.push_back('{frame: 64'h06, nbits: 8, csLow: 16, done: 1'b0});
      expLat += 18;
`endif
      expQ.push_back('{frame: expFrame, nbits: expBits, csLow: expCsLow, done: 1'b1});
      target_address = addr;
      write_data     = data;
      write_size     = size;
      start_write    = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
         if (n == 1) begin
            checkOutput("csLowAtCycle1", 64'(cs), 64'd0);
            checkOutput("busyAtCycle1", 64'(busy), 64'd1);
            checkOutput("sclkAtCycle1", 64'(sclk), 64'd0);
            target_address = ~addr;
            write_data     = ~data;
            write_size     = ~size;
            if (dropEarly) start_write = 1'b0;
         end
      end while (write_done !== 1'b1 && n < 400);
      checkOutput("doneLatency", 64'(n), 64'(expLat));
      checkOutput("busyAtDone", 64'(busy), 64'd0);
      checkOutput("csAtDone", 64'(cs), 64'd1);
      if (dropEarly) begin
         @(posedge clk); #1;
         checkOutput("donePulseWidth", 64'(write_done), 64'd0);
      end else begin
         bad = 0;
         repeat (20) begin
            @(posedge clk); #1;
            if (write_done !== 1'b1 || cs !== 1'b1 || busy !== 1'b0) bad++;
         end
         checkOutput("doneHeldNoRestart", 64'(bad), 64'd0);
         start_write = 1'b0;
         @(posedge clk); #1;
         checkOutput("doneDropsAfterStart", 64'(write_done), 64'd0);
      end
   endtask

   // Start a frame and reset it 40 cycles after cs falls
   task automatic applyAbort(input logic [23:0] addr, input logic [31:0] data);
      int n;
`ifdef MEM_WRITE_WREN_EN
      expQ.push_back('{frame: 64'h06, nbits: 8, csLow: 16, done: 1'b0});
`endif
      target_address = addr;
      write_data     = data;
      write_size     = 2'd2;
      start_write    = 1'b1;
      n = 0;
      do begin
         @(posedge clk); #1;
         n++;
      end while (cs !== 1'b0 && n < 20);
      checkOutput("abortFrameStarted", 64'(cs), 64'd0);
      repeat (39) @(posedge clk);
      #1;
      rst         = 1'b1;
      start_write = 1'b0;
      @(posedge clk); #1;
      checkOutput("abortCs", 64'(cs), 64'd1);
      checkOutput("abortSclk", 64'(sclk), 64'd0);
      checkOutput("abortMosi", 64'(mosi), 64'd0);
      checkOutput("abortBusy", 64'(busy), 64'd0);
      checkOutput("abortDone", 64'(write_done), 64'd0);
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   // Main sequence of directed vectors
   initial begin
      rst            = 1'b1;
      target_address = '0;
      write_data     = '0;
      write_size     = '0;
      start_write    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("resetCs", 64'(cs), 64'd1);
      checkOutput("resetSclk", 64'(sclk), 64'd0);
      checkOutput("resetMosi", 64'(mosi), 64'd0);
      checkOutput("resetBusy", 64'(busy), 64'd0);
      checkOutput("resetDone", 64'(write_done), 64'd0);
      rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      $display("[TB] 4-byte write, held start");
      applyStimulus(24'h000010, 32'hDDCCBBAA, 2'd2, 64'h02000010AABBCCDD, 64, 128, 1'b0);
      $display("[TB] 1-byte write at top address, start dropped mid-frame");
      applyStimulus(24'hFFFFFF, 32'h12345678, 2'd0, 64'h00000002FFFFFF78, 40, 80, 1'b1);
      $display("[TB] reserved size, back-to-back with minimum gap");
      applyStimulus(24'h123456, 32'h11223344, 2'd3, 64'h0212345644332211, 64, 128, 1'b1);
      $display("[TB] 2-byte write");
      applyStimulus(24'hABCDEF, 32'hCAFEBEEF, 2'd1, 64'h000002ABCDEFEFBE, 48, 96, 1'b0);
      $display("[TB] reset mid-frame");
      applyAbort(24'h555555, 32'hA5A5A5A5);
      $display("[TB] clean frame after abort");
      applyStimulus(24'h00A5F0, 32'h01020304, 2'd2, 64'h0200A5F004030201, 64, 128, 1'b1);

      repeat (5) @(posedge clk);
      #1;
      checkOutput("scoreboardEmpty", 64'(expQ.size()), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
